// File: rtl/key_cond.sv
// Button conditioning for the 60 s counter: synchronises and debounces the pause
// and clear keys, toggles a run/pause level and stretches the clear level.
module key_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CLR_STRETCH     = 60000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic clr,
    input  logic key_stay,
    input  logic key_clear,
    output logic stay_o,
    output logic clear_o,
    output logic stay_evt,
    output logic clear_evt
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESS_CHK = 2'd1;
    localparam logic [1:0] DOWN      = 2'd2;
    localparam logic [1:0] REL_CHK   = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(CLR_STRETCH - 1);

    logic [1:0] raw;
    logic [1:0] press;
    logic       clear_idle;

    // Index 0 is the pause key, index 1 the clear key.
    assign raw = {key_clear, key_stay};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic             s1_reg;
            logic             s2_reg;
            logic [1:0]       state_reg;
            logic [1:0]       state_next;
            logic [CNT_W-1:0] dcnt_reg;
            logic [CNT_W-1:0] dcnt_next;
            logic             press_next;

            always_ff @(posedge clk) begin
                if (clr) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    state_reg <= IDLE;
                    dcnt_reg  <= '0;
                end else begin
                    s1_reg    <= raw[gi];
                    s2_reg    <= s1_reg;
                    state_reg <= state_next;
                    dcnt_reg  <= dcnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                dcnt_next  = dcnt_reg;
                press_next = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (s2_reg) begin
                            state_next = PRESS_CHK;
                            dcnt_next  = CNT_W'(1);
                        end
                    end
                    PRESS_CHK: begin
                        if (!s2_reg) begin
                            state_next = IDLE;
                            dcnt_next  = '0;
                        end else if (dcnt_reg == DB_LAST) begin
                            state_next = DOWN;
                            dcnt_next  = '0;
                            press_next = 1'b1;
                        end else begin
                            dcnt_next = dcnt_reg + CNT_W'(1);
                        end
                    end
                    DOWN: begin
                        if (!s2_reg) begin
                            state_next = REL_CHK;
                            dcnt_next  = CNT_W'(1);
                        end
                    end
                    default: begin
                        if (s2_reg) begin
                            state_next = DOWN;
                            dcnt_next  = '0;
                        end else if (dcnt_reg == DB_LAST) begin
                            state_next = IDLE;
                            dcnt_next  = '0;
                        end else begin
                            dcnt_next = dcnt_reg + CNT_W'(1);
                        end
                    end
                endcase
            end

            assign press[gi] = press_next;

            // The clear level may only drop once the clear key is fully released.
            if (gi == 1) begin : g_idle
                assign clear_idle = (state_reg == IDLE);
            end
        end
    endgenerate

    logic             stay_reg;
    logic             stay_evt_reg;
    logic             clear_reg;
    logic             clear_evt_reg;
    logic [CNT_W-1:0] scnt_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            stay_reg      <= 1'b0;
            stay_evt_reg  <= 1'b0;
            clear_reg     <= 1'b0;
            clear_evt_reg <= 1'b0;
            scnt_reg      <= '0;
        end else begin
            stay_evt_reg  <= press[0];
            clear_evt_reg <= press[1];
            if (press[0]) begin
                stay_reg <= ~stay_reg;
            end
            if (press[1]) begin
                clear_reg <= 1'b1;
                scnt_reg  <= STRETCH_LOAD;
            end else begin
                if (scnt_reg != '0) begin
                    scnt_reg <= scnt_reg - CNT_W'(1);
                end
                if (clear_reg && scnt_reg == '0 && clear_idle) begin
                    clear_reg <= 1'b0;
                end
            end
        end
    end

    assign stay_o    = stay_reg;
    assign stay_evt  = stay_evt_reg;
    assign clear_o   = clear_reg;
    assign clear_evt = clear_evt_reg;

endmodule

// File: tb/tb_key_cond.sv
// Randomised and directed bench for key_cond with a hysteresis-style debounce
// model (level flips after DB consecutive opposite samples).
module tb_key_cond;

    localparam int DB = 4;
    localparam int CS = 10;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic key_stay = 1'b0;
    logic key_clear = 1'b0;
    logic stay_o, clear_o, stay_evt, clear_evt;

    key_cond #(.DEBOUNCE_CYCLES(DB), .CLR_STRETCH(CS), .CNT_W(W)) dut (
        .clk(clk), .clr(clr), .key_stay(key_stay), .key_clear(key_clear),
        .stay_o(stay_o), .clear_o(clear_o), .stay_evt(stay_evt), .clear_evt(clear_evt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: 2-sample input delay, then a level that flips after DB
    // consecutive samples disagreeing with it; press = flip to 1.
    bit h1 [2];
    bit h2 [2];
    bit lvl [2];
    int run [2];
    bit fire [2];
    bit m_stay, m_sevt, m_cevt, m_clear;
    int rem;
    bit chk_en = 1'b0;

    initial forever begin
        bit old_idle;
        bit rawv [2];
        @(posedge clk);
        rawv[0] = key_stay;
        rawv[1] = key_clear;
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                h1[k] = 0; h2[k] = 0; lvl[k] = 0; run[k] = 0;
            end
            m_stay = 0; m_sevt = 0; m_cevt = 0; m_clear = 0; rem = 0;
            chk_en = 1'b1;
        end else begin
            old_idle = !lvl[1] && run[1] == 0;
            for (int k = 0; k < 2; k++) begin
                fire[k] = 0;
                if (h2[k] != lvl[k]) run[k]++;
                else run[k] = 0;
                if (run[k] == DB) begin
                    lvl[k]  = !lvl[k];
                    run[k]  = 0;
                    fire[k] = lvl[k];
                end
                h2[k] = h1[k];
                h1[k] = rawv[k];
            end
            m_sevt = fire[0];
            m_cevt = fire[1];
            if (fire[0]) m_stay = !m_stay;
            if (fire[1]) begin
                m_clear = 1;
                rem = CS - 1;
            end else begin
                if (m_clear && rem == 0 && old_idle) m_clear = 0;
                if (rem != 0) rem--;
            end
        end
        #2;
        if (chk_en) begin
            check("cyc_stay_o", stay_o, m_stay);
            check("cyc_stay_evt", stay_evt, m_sevt);
            check("cyc_clear_o", clear_o, m_clear);
            check("cyc_clear_evt", clear_evt, m_cevt);
        end
    end

    // Directed-window observation counters, written only by the stimulus process.
    int k_idx, first_stay, n_sevt, n_cevt, n_chi, n_both;

    task automatic win_reset();
        k_idx = 0; first_stay = -1; n_sevt = 0; n_cevt = 0; n_chi = 0; n_both = 0;
    endtask

    task automatic step(input bit ks, input bit kc, input bit rst);
        @(negedge clk);
        key_stay = ks; key_clear = kc; clr = rst;
        @(posedge clk);
        #3;
        if (stay_evt && first_stay < 0) first_stay = k_idx;
        if (stay_evt) n_sevt++;
        if (clear_evt) n_cevt++;
        if (clear_o) n_chi++;
        if (stay_evt && clear_evt) n_both++;
        k_idx++;
    endtask

    task automatic steps(input int n, input bit ks, input bit kc);
        for (int i = 0; i < n; i++) step(ks, kc, 1'b0);
    endtask

    initial begin
        int len_s, len_c;
        bit vs, vc;

        step(0, 0, 1); step(0, 0, 1);
        check("rst_stay_o", stay_o, 0);
        check("rst_clear_o", clear_o, 0);
        check("rst_stay_evt", stay_evt, 0);
        check("rst_clear_evt", clear_evt, 0);

        // Held pause key: event at edge DB+1 after the rise, no repeat.
        win_reset();
        steps(20, 1, 0);
        steps(10, 0, 0);
        check("hold_first_evt_edge", first_stay, 5);
        check("hold_evt_count", n_sevt, 1);
        check("hold_stay_o", stay_o, 1);

        // Bouncy pause key: 3-high/1-low bursts then steady high.
        win_reset();
        for (int r = 0; r < 3; r++) begin
            steps(3, 1, 0);
            steps(1, 0, 0);
        end
        steps(12, 1, 0);
        steps(10, 0, 0);
        check("bounce_evt_count", n_sevt, 1);
        check("bounce_stay_o", stay_o, 0);

        // Two clean presses.
        win_reset();
        steps(10, 1, 0);
        steps(10, 0, 0);
        check("two_press_mid_stay_o", stay_o, 1);
        steps(10, 1, 0);
        steps(10, 0, 0);
        check("two_press_evt_count", n_sevt, 2);
        check("two_press_stay_o", stay_o, 0);

        // Clear glitch.
        win_reset();
        steps(2, 0, 1);
        steps(20, 0, 0);
        check("glitch_clear_evt", n_cevt, 0);
        check("glitch_clear_hi", n_chi, 0);

        // Short clear press: stretched to exactly CS cycles.
        win_reset();
        steps(6, 0, 1);
        steps(20, 0, 0);
        check("short_clear_evt", n_cevt, 1);
        check("short_clear_hi", n_chi, 10);

        // Long clear press: held until release debounce completes.
        win_reset();
        steps(30, 0, 1);
        steps(20, 0, 0);
        check("long_clear_evt", n_cevt, 1);
        check("long_clear_hi", n_chi, 31);

        // Simultaneous presses.
        win_reset();
        steps(10, 1, 1);
        steps(20, 0, 0);
        check("both_same_cycle", n_both, 1);
        check("both_clear_evt", n_cevt, 1);
        check("both_stay_o", stay_o, 1);

        // Reset during the clear stretch.
        win_reset();
        steps(8, 0, 1);
        check("pre_rst_clear_o", clear_o, 1);
        step(0, 1, 1);
        check("mid_stretch_rst_clear_o", clear_o, 0);
        step(0, 0, 0);

        // Random bouncy keys with occasional resets.
        len_s = 0; len_c = 0; vs = 0; vc = 0;
        for (int i = 0; i < 4000; i++) begin
            if (len_s == 0) begin vs = !vs; len_s = $urandom_range(1, 9); end
            if (len_c == 0) begin vc = !vc; len_c = $urandom_range(1, 20); end
            len_s--; len_c--;
            step(vs, vc, ($urandom_range(0, 599) == 0));
        end
        steps(30, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_cond.md
Name: key_cond

Overview:
- Button-conditioning stage directly upstream of the 60 s counter.
- Takes the two raw Basys2 push-buttons (pause and clear), synchronises them to the 50 MHz clock and debounces them.
- Produces:
  - a run/pause level that toggles on each debounced press of the pause key;
  - a clear level stretched long enough to be caught by the counter's 1 Hz clock domain.
- Replaces the direct wiring of raw buttons into the counter's stay/clr inputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz); must be >= 2.
- CLR_STRETCH, 60000000, minimum number of clk cycles clear_o stays high after a debounced clear press; must exceed one clk_1s period.
- CNT_W, 26, width of the debounce and stretch counters; must hold max(DEBOUNCE_CYCLES, CLR_STRETCH).

Ports:
- clk  input  1  50 MHz system clock; all logic on its rising edge.
- clr  input  1  synchronous, active-high reset.
- key_stay  input  1  raw pause button, active-high, asynchronous, bouncy.
- key_clear  input  1  raw clear button, active-high, asynchronous, bouncy.
- stay_o  output  1  pause level to the counter; 1 = paused.
- clear_o  output  1  clear level to the counter; 1 = clear.
- stay_evt  output  1  one-cycle pulse on each accepted pause-key press.
- clear_evt  output  1  one-cycle pulse on each accepted clear-key press.

Behaviour:
- Reset (clr=1 at an edge): sync flops, FSMs, counters and all outputs go to 0. FSMs go to IDLE and stay_o=0 (running).
- Key held through reset release: treated as a fresh press, accepted after debounce.
- Synchroniser: one 2-flop chain per key. FSMs use only the second flop (s2).
- Per-key FSM (two independent identical instances) with a debounce counter dcnt:
  - IDLE: if s2=1, go to PRESS_CHK with dcnt=1; else stay.
  - PRESS_CHK: if s2=0, go to IDLE with dcnt=0. Else if dcnt=DEBOUNCE_CYCLES-1, go to DOWN with dcnt=0 and fire the press event. Else dcnt+1.
  - DOWN: if s2=0, go to REL_CHK with dcnt=1; else stay.
  - REL_CHK: if s2=1, go to DOWN with dcnt=0. Else if dcnt=DEBOUNCE_CYCLES-1, go to IDLE with dcnt=0 (no event). Else dcnt+1.
- Press timing and glitches:
  - Press event fires after exactly DEBOUNCE_CYCLES consecutive s2=1 samples.
  - Raw rising edge just before edge 0 → s2 high after edge 1 → event registered at edge DEBOUNCE_CYCLES+1.
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
  - Release bounce shorter than DEBOUNCE_CYCLES produces no second event.
- Pause path:
  - On the pause-key press event, stay_o inverts and stay_evt=1 for that one cycle (registered; same edge as entry to DOWN).
  - Holding the key produces no further toggles.
- Clear path:
  - On the clear-key press event: clear_evt=1 for one cycle, clear_o=1, stretch counter loaded with CLR_STRETCH-1.
  - Each following cycle the stretch counter decrements while non-zero.
  - clear_o falls at the first edge where the stretch counter is 0 AND the clear FSM is in IDLE.
  - Result: clear_o high for max(CLR_STRETCH, held time + release debounce) cycles.
  - A new clear press while clear_o is high reloads the stretch counter.
- Keys are independent; simultaneous presses are both honoured in the same cycle.
- clear_o does not modify stay_o.
- Reset mid-debounce or mid-stretch aborts immediately; no event is emitted.
- Counters saturate logically via the FSM; no wrap can occur with legal parameters.

Test Plan (DEBOUNCE_CYCLES=4, CLR_STRETCH=10, CNT_W=8):
- Reset, hold key_stay=1 for 20 cycles, then release → one stay_evt pulse at edge 5 after the rise; stay_o 0→1 at that edge; no further change.
- key_stay pulses of 3 cycles separated by 1 low cycle (bounce), then steady high → exactly one toggle, 4 samples after the last low sample.
- Two clean pause presses, each 10 cycles high with 10 cycles low between → stay_o goes 0→1→0; exactly two stay_evt pulses.
- key_clear high for 2 cycles (glitch) → no clear_evt; clear_o stays 0.
- key_clear high for 6 cycles → clear_evt once; clear_o high for exactly 10 cycles.
- key_clear held 30 cycles → clear_o stays high until the clear FSM reaches IDLE, 4 cycles after s2 falls.
- Both keys pressed together → stay_evt and clear_evt fire in the same cycle.
- Reset asserted mid-stretch → clear_o=0 at the next edge.
